// File: rtl/scancode_pkg.sv
// Shared types and constants for the scancode-to-display controller.
// Included by every module of the block through a package import.
package scancode_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Address width for a digit index; never narrower than one bit.
    function automatic int addr_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector for a level signal.
// One pulse per low-to-high transition, however long the level holds.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev_level;

    // Remember the level seen at the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_level <= 1'b0;
        else        prev_level <= level;
    end

    assign rise = level & ~prev_level;

endmodule

// File: rtl/scancode_disp_ctrl.sv
// Scancode history keeper that sweeps hex digits into a display buffer.
// Filters break codes, buffers one byte during a sweep, reports drops.
module scancode_disp_ctrl
    import scancode_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int FILTER_BREAK = 1,
    parameter  int COUNT_W      = 8,
    localparam int AW           = addr_w(NUM_DIGITS)
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic [7:0]         scan_code,
    input  logic               scan_valid,
    input  logic               clear,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [3:0]         wr_nibble,
    output logic               busy,
    output logic               drop,
    output logic [COUNT_W-1:0] key_count
);

    localparam int HW = NUM_DIGITS * 4;
    localparam logic [AW-1:0] LAST = AW'(NUM_DIGITS - 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [HW-1:0]        hist_q, hist_d;
    logic [COUNT_W-1:0]   cnt_d;
    logic                 brk_q, brk_d;
    logic                 bpend_q, bpend_d;
    logic                 cpend_q, cpend_d;
    logic [7:0]           pcode_q, pcode_d;
    logic                 wr_en_d, busy_d, drop_d;
    logic [AW-1:0]        wr_addr_d;
    logic [3:0]           wr_nibble_d;
    logic                 rise;
    logic                 ev;

    rise_det u_rise (
        .clk   (reloj),
        .rst_n (reset),
        .level (scan_valid),
        .rise  (rise)
    );

    // Qualify each new byte, then decide history, pending slot and outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        cnt_d       = key_count;
        brk_d       = brk_q;
        bpend_d     = bpend_q;
        cpend_d     = cpend_q;
        pcode_d     = pcode_q;
        wr_en_d     = 1'b0;
        busy_d      = 1'b0;
        drop_d      = 1'b0;
        wr_addr_d   = wr_addr;
        wr_nibble_d = wr_nibble;
        ev          = 1'b0;

        if (rise) begin
            if (FILTER_BREAK != 0 && scan_code == BREAK_CODE) brk_d = 1'b1;
            else if (FILTER_BREAK != 0 && brk_q)              brk_d = 1'b0;
            else                                              ev    = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    hist_d  = '0;
                    cnt_d   = '0;
                    brk_d   = 1'b0;
                    drop_d  = ev;
                    idx_d   = '0;
                    state_d = ST_SWEEP;
                end else if (ev) begin
                    hist_d  = (hist_q << 8) | HW'(scan_code);
                    cnt_d   = key_count + COUNT_W'(1);
                    idx_d   = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                wr_en_d     = 1'b1;
                busy_d      = 1'b1;
                wr_addr_d   = idx_q;
                wr_nibble_d = 4'(hist_q >> {idx_q, 2'b00});
                idx_d       = idx_q + AW'(1);

                if (clear) begin
                    drop_d  = bpend_q;
                    bpend_d = 1'b0;
                    cpend_d = 1'b1;
                end
                if (ev) begin
                    if (cpend_d) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d  = bpend_d;
                        bpend_d = 1'b1;
                        pcode_d = scan_code;
                    end
                end

                if (idx_q == LAST) begin
                    idx_d = '0;
                    if (cpend_d) begin
                        hist_d  = '0;
                        cnt_d   = '0;
                        brk_d   = 1'b0;
                        cpend_d = 1'b0;
                    end else if (bpend_d) begin
                        hist_d  = (hist_q << 8) | HW'(pcode_d);
                        cnt_d   = key_count + COUNT_W'(1);
                        bpend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset starts a refresh sweep of zeros.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SWEEP;
            idx_q     <= '0;
            hist_q    <= '0;
            key_count <= '0;
            brk_q     <= 1'b0;
            bpend_q   <= 1'b0;
            cpend_q   <= 1'b0;
            pcode_q   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_nibble <= '0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hist_q    <= hist_d;
            key_count <= cnt_d;
            brk_q     <= brk_d;
            bpend_q   <= bpend_d;
            cpend_q   <= cpend_d;
            pcode_q   <= pcode_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_nibble <= wr_nibble_d;
            busy      <= busy_d;
            drop      <= drop_d;
        end
    end

endmodule

// File: tb/tb_scancode_disp_ctrl.sv
// Directed bench for scancode_disp_ctrl with and without break filtering.
// A small display-buffer model collects written digits for checking.
module tb_scancode_disp_ctrl;

    logic       reloj = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       clear = 1'b0;

    logic       wr_en, busy, drop;
    logic [1:0] wr_addr;
    logic [3:0] wr_nibble;
    logic [7:0] key_count;

    logic       nf_wr_en, nf_busy, nf_drop;
    logic [1:0] nf_wr_addr;
    logic [3:0] nf_wr_nibble;
    logic [7:0] nf_key_count;

    int checks = 0;
    int fails  = 0;
    int cnt_wr = 0;
    int cnt_wr_nf = 0;
    int cnt_drop = 0;
    int w0, wn0, d0;

    logic [3:0] disp [4] = '{default: 4'h0};
    logic [3:0] disp_nf [4] = '{default: 4'h0};

    scancode_disp_ctrl #(
        .NUM_DIGITS(4), .FILTER_BREAK(1), .COUNT_W(8)
    ) dut (
        .reloj(reloj), .reset(reset),
        .scan_code(scan_code), .scan_valid(scan_valid),
        .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_nibble(wr_nibble),
        .busy(busy), .drop(drop), .key_count(key_count)
    );

    scancode_disp_ctrl #(
        .NUM_DIGITS(4), .FILTER_BREAK(0), .COUNT_W(8)
    ) dut_nf (
        .reloj(reloj), .reset(reset),
        .scan_code(scan_code), .scan_valid(scan_valid),
        .clear(clear),
        .wr_en(nf_wr_en), .wr_addr(nf_wr_addr),
        .wr_nibble(nf_wr_nibble),
        .busy(nf_busy), .drop(nf_drop), .key_count(nf_key_count)
    );

    always #10 reloj = ~reloj;

    // Display buffer model: latch digits on each write strobe.
    always @(posedge reloj) begin
        if (wr_en) begin
            disp[wr_addr] <= wr_nibble;
            cnt_wr <= cnt_wr + 1;
        end
        if (nf_wr_en) begin
            disp_nf[nf_wr_addr] <= nf_wr_nibble;
            cnt_wr_nf <= cnt_wr_nf + 1;
        end
        if (drop) cnt_drop <= cnt_drop + 1;
    end

    function automatic logic [15:0] word(input logic [3:0] d [4]);
        return {d[3], d[2], d[1], d[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge reloj);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] code, input int hold,
                        input int gap);
        scan_code  = code;
        scan_valid = 1'b1;
        tick(hold);
        scan_valid = 1'b0;
        tick(1);
        tick(gap);
    endtask

    initial begin
        tick(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_nibble", wr_nibble, 0);
        check("rst_count", key_count, 0);

        reset = 1'b1;
        w0 = cnt_wr;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("refresh_wr_en", wr_en, 1);
            check("refresh_busy", busy, 1);
            check("refresh_addr", wr_addr, i);
            check("refresh_nibble", wr_nibble, 0);
        end
        tick(1);
        check("refresh_end_wr_en", wr_en, 0);
        check("refresh_end_busy", busy, 0);
        check("refresh_writes", cnt_wr - w0, 4);
        check("refresh_count", key_count, 0);

        w0 = cnt_wr;
        send(8'h1C, 100, 8);
        check("held_writes", cnt_wr - w0, 4);
        check("held_disp", word(disp), 16'h001C);
        check("held_count", key_count, 1);
        check("held_busy", busy, 0);

        send(8'h32, 1, 8);
        check("two_disp", word(disp), 16'h1C32);
        check("two_count", key_count, 2);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(8);
        check("clr_count", key_count, 0);
        check("clr_count_nf", nf_key_count, 0);
        check("clr_disp", word(disp), 16'h0000);

        w0  = cnt_wr;
        wn0 = cnt_wr_nf;
        send(8'h1C, 1, 8);
        send(8'hF0, 1, 8);
        send(8'h1C, 1, 8);
        send(8'h32, 1, 8);
        check("filt_writes", cnt_wr - w0, 8);
        check("filt_disp", word(disp), 16'h1C32);
        check("filt_count", key_count, 2);
        check("nofilt_writes", cnt_wr_nf - wn0, 16);
        check("nofilt_disp", word(disp_nf), 16'h1C32);
        check("nofilt_count", nf_key_count, 4);

        d0 = cnt_drop;
        w0 = cnt_wr;
        send(8'h11, 1, 0);
        send(8'h22, 1, 0);
        send(8'h33, 1, 0);
        check("b2b_wr_en", wr_en, 1);
        check("b2b_addr", wr_addr, 0);
        check("b2b_nibble", wr_nibble, 3);
        tick(8);
        check("ovr_drops", cnt_drop - d0, 1);
        check("ovr_writes", cnt_wr - w0, 8);
        check("ovr_disp", word(disp), 16'h1133);
        check("ovr_count", key_count, 4);

        send(8'h44, 1, 0);
        scan_code  = 8'h55;
        scan_valid = 1'b1;
        tick(1);
        scan_valid = 1'b0;
        tick(1);
        check("mid_addr", wr_addr, 2);
        check("mid_wr_en", wr_en, 1);
        reset = 1'b0;
        #1;
        check("async_wr_en", wr_en, 0);
        check("async_busy", busy, 0);
        check("async_count", key_count, 0);
        tick(2);
        reset = 1'b1;
        w0 = cnt_wr;
        tick(12);
        check("rerst_writes", cnt_wr - w0, 4);
        check("rerst_disp", word(disp), 16'h0000);
        check("rerst_count", key_count, 0);

        send(8'hE0, 1, 8);
        check("ext_disp", word(disp), 16'h00E0);
        check("ext_count", key_count, 1);

        d0 = cnt_drop;
        w0 = cnt_wr;
        scan_code  = 8'h77;
        scan_valid = 1'b1;
        clear      = 1'b1;
        tick(1);
        check("clrev_drop", drop, 1);
        clear      = 1'b0;
        scan_valid = 1'b0;
        tick(8);
        check("clrev_drops", cnt_drop - d0, 1);
        check("clrev_writes", cnt_wr - w0, 4);
        check("clrev_disp", word(disp), 16'h0000);
        check("clrev_count", key_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
